// File: rtl/crtc_init_sequencer.sv
// -----------------------------------------------------------------------------
// crtc_init_sequencer
//
// Bus-owning configuration controller that sits between the CPU-side I/O
// decode and the UM6845R register port. On request it programs all sixteen
// CRTC registers (R0..R15) from one of four preset banks, honouring a
// per-register write mask. While it runs the CPU is held off. When it is
// done, the CRTC address register is restored to the last address the CPU
// selected.
//
// Each register takes two cycles: a select write (RS=0, DI=index) and then a
// data write (RS=1, DI=bank value). A final restore write (RS=0, DI=shadow)
// ends the run. A run is always 33 cycles long. Masked registers keep their
// two slots, but their strobes are suppressed.
//
// Build option:
//   CRTC_SEQ_AUTOINIT_EN  when defined, a run with bank 0 (CPC standard) and
//                         every register enabled starts by itself after
//                         nRESET is released.
//
// Ports:
//   CLOCK        system clock; every CRTC strobe lasts one CLOCK cycle
//   nRESET       synchronous, active-low reset
//   start        pulse that requests a run; only sampled in IDLE
//   preset_sel   bank for the run (0 standard, 1 overscan, 2 small, 3 user)
//   mask         bit i = 1 writes Ri during the run
//   cfg_we       write strobe for the user bank (bank 3)
//   cfg_idx      user bank index
//   cfg_data     user bank data
//   cpu_en, cpu_ncs, cpu_rnw, cpu_rs, cpu_di
//                CPU-side CRTC strobes and write data
//   crtc_enable, crtc_ncs, crtc_rnw, crtc_rs, crtc_di
//                to the CRTC ENABLE / nCS / R_nW / RS / DI pins
//   cpu_wait     CPU must hold or retry its access
//   busy         a run is in progress
//   done         one-cycle pulse in the cycle after the restore write
// -----------------------------------------------------------------------------
module crtc_init_sequencer (
  input  logic        CLOCK,
  input  logic        nRESET,
  input  logic        start,
  input  logic [1:0]  preset_sel,
  input  logic [15:0] mask,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_idx,
  input  logic [7:0]  cfg_data,
  input  logic        cpu_en,
  input  logic        cpu_ncs,
  input  logic        cpu_rnw,
  input  logic        cpu_rs,
  input  logic [7:0]  cpu_di,
  output logic        crtc_enable,
  output logic        crtc_ncs,
  output logic        crtc_rnw,
  output logic        crtc_rs,
  output logic [7:0]  crtc_di,
  output logic        cpu_wait,
  output logic        busy,
  output logic        done
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;  // CPU owns the CRTC port
  localparam logic [1:0] ST_SEL  = 2'd1;  // register-select write
  localparam logic [1:0] ST_DAT  = 2'd2;  // register-data write
  localparam logic [1:0] ST_FIN  = 2'd3;  // address-restore write

  localparam logic [3:0] LAST_IDX = 4'd15;

  // Preset banks, element i is the value written to Ri.
  localparam logic [7:0] BANK_STD [16] = '{
    8'h3F, 8'h28, 8'h2E, 8'h8E, 8'h26, 8'h00, 8'h19, 8'h1E,
    8'h00, 8'h07, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00
  };
  localparam logic [7:0] BANK_OVS [16] = '{
    8'h3F, 8'h30, 8'h32, 8'h8E, 8'h26, 8'h00, 8'h22, 8'h23,
    8'h00, 8'h07, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00
  };
  localparam logic [7:0] BANK_SML [16] = '{
    8'h3F, 8'h20, 8'h2A, 8'h8E, 8'h26, 8'h00, 8'h20, 8'h22,
    8'h00, 8'h07, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00
  };

  logic [1:0]  state;
  logic [3:0]  idx;
  logic [1:0]  preset_q;
  logic [15:0] mask_q;
  logic [4:0]  shadow;
  logic [7:0]  user_bank [16];

  logic        go;
  logic [1:0]  go_preset;
  logic [15:0] go_mask;
  logic        cpu_addr_wr;
  logic        slot_we;
  logic [7:0]  bank_data;

  // A CPU write to the CRTC address register (RS=0); its low five bits are
  // the address the restore write puts back at the end of a run.
  assign cpu_addr_wr = cpu_en & ~cpu_ncs & ~cpu_rnw & ~cpu_rs;

`ifdef CRTC_SEQ_AUTOINIT_EN
  // Set throughout reset and consumed by the first IDLE cycle afterwards,
  // which launches a standard-bank, all-registers run without CPU action.
  logic init_pending;

  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      init_pending <= 1'b1;
    end else if (state == ST_IDLE) begin
      init_pending <= 1'b0;
    end
  end

  assign go        = start | init_pending;
  assign go_preset = init_pending ? 2'd0 : preset_sel;
  assign go_mask   = init_pending ? 16'hFFFF : mask;
`else
  assign go        = start;
  assign go_preset = preset_sel;
  assign go_mask   = mask;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer FSM, register index, latched run parameters, address shadow
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      state    <= ST_IDLE;
      idx      <= 4'd0;
      preset_q <= 2'd0;
      mask_q   <= 16'h0000;
      shadow   <= 5'd0;
      done     <= 1'b0;
    end else begin
      // done lands in the first IDLE cycle after the restore write.
      done <= (state == ST_FIN);

      case (state)
        ST_IDLE: begin
          // The CPU cycle is forwarded in this same cycle, so an address
          // write that coincides with start is still captured.
          if (cpu_addr_wr) begin
            shadow <= cpu_di[4:0];
          end
          if (go) begin
            state    <= ST_SEL;
            idx      <= 4'd0;
            preset_q <= go_preset;
            mask_q   <= go_mask;
          end
        end
        ST_SEL: begin
          state <= ST_DAT;
        end
        ST_DAT: begin
          if (idx == LAST_IDX) begin
            state <= ST_FIN;
          end else begin
            state <= ST_SEL;
            idx   <= idx + 4'd1;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // User bank (bank 3): writable at any time, read at the DAT slot, so a write
  // to a register the run has not reached yet still takes effect.
  // ---------------------------------------------------------------------------
  // NOTE: this bank has to read back 00 after reset, so every entry is
  // cleared explicitly; the table stays in flops, not in a RAM macro.
  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      for (int i = 0; i < 16; i++) begin
        user_bank[i] <= 8'h00;
      end
    end else if (cfg_we) begin
      user_bank[cfg_idx] <= cfg_data;
    end
  end

  // Value for the current DAT slot from the latched bank.
  // NOTE: every always_comb output gets a default first; this prevents
  // latches on paths that a case arm does not assign.
  always_comb begin
    bank_data = 8'h00;
    case (preset_q)
      2'd0:    bank_data = BANK_STD[idx];
      2'd1:    bank_data = BANK_OVS[idx];
      2'd2:    bank_data = BANK_SML[idx];
      default: bank_data = user_bank[idx];
    endcase
  end

  assign slot_we = mask_q[idx];

  // ---------------------------------------------------------------------------
  // CRTC port mux. In IDLE the CPU strobes pass straight through. In every
  // other state the outputs depend only on registered state, so a CPU glitch
  // cannot reach the CRTC during a run.
  // ---------------------------------------------------------------------------
  always_comb begin
    crtc_enable = cpu_en;
    crtc_ncs    = cpu_ncs;
    crtc_rnw    = cpu_rnw;
    crtc_rs     = cpu_rs;
    crtc_di     = cpu_di;
    case (state)
      ST_SEL: begin
        // A masked register keeps its slot but with the bus released.
        crtc_enable = slot_we;
        crtc_ncs    = ~slot_we;
        crtc_rnw    = ~slot_we;
        crtc_rs     = 1'b0;
        crtc_di     = {4'b0000, idx};
      end
      ST_DAT: begin
        crtc_enable = slot_we;
        crtc_ncs    = ~slot_we;
        crtc_rnw    = ~slot_we;
        crtc_rs     = 1'b1;
        crtc_di     = bank_data;
      end
      ST_FIN: begin
        // The restore write always happens, regardless of the mask.
        crtc_enable = 1'b1;
        crtc_ncs    = 1'b0;
        crtc_rnw    = 1'b0;
        crtc_rs     = 1'b0;
        crtc_di     = {3'b000, shadow};
      end
      default: begin
      end
    endcase
  end

  assign busy     = (state != ST_IDLE);
  assign cpu_wait = busy;

endmodule

// File: tb/tb_crtc_init_sequencer.sv
// -----------------------------------------------------------------------------
// tb_crtc_init_sequencer
//
// Scoreboard bench. Whenever the bench drives a start or a forwarded CPU
// write, it queues every CRTC write strobe it expects (cycle, RS, DI) and the
// cycle of every done pulse. A negedge monitor pops these queues as the DUT
// produces strobes and done pulses. On every cycle the monitor also compares
// busy and cpu_wait with the run window the bench expects.
// -----------------------------------------------------------------------------
module tb_crtc_init_sequencer;

  logic        CLOCK = 1'b0;
  logic        nRESET = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  preset_sel = 2'd0;
  logic [15:0] mask = 16'h0000;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_idx = 4'd0;
  logic [7:0]  cfg_data = 8'h00;
  logic        cpu_en = 1'b0;
  logic        cpu_ncs = 1'b1;
  logic        cpu_rnw = 1'b1;
  logic        cpu_rs = 1'b0;
  logic [7:0]  cpu_di = 8'h00;
  logic        crtc_enable, crtc_ncs, crtc_rnw, crtc_rs;
  logic [7:0]  crtc_di;
  logic        cpu_wait, busy, done;

  crtc_init_sequencer dut (
    .CLOCK       (CLOCK),
    .nRESET      (nRESET),
    .start       (start),
    .preset_sel  (preset_sel),
    .mask        (mask),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_data    (cfg_data),
    .cpu_en      (cpu_en),
    .cpu_ncs     (cpu_ncs),
    .cpu_rnw     (cpu_rnw),
    .cpu_rs      (cpu_rs),
    .cpu_di      (cpu_di),
    .crtc_enable (crtc_enable),
    .crtc_ncs    (crtc_ncs),
    .crtc_rnw    (crtc_rnw),
    .crtc_rs     (crtc_rs),
    .crtc_di     (crtc_di),
    .cpu_wait    (cpu_wait),
    .busy        (busy),
    .done        (done)
  );

  always #5 CLOCK = ~CLOCK;

  // Cycle k is the interval that follows the k-th rising edge.
  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic       rs;
    logic [7:0] di;
  } strobe_t;

  strobe_t exp_q[$];
  int      done_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  // Expected run window: busy and cpu_wait must be high for cycles in
  // [busy_lo, busy_hi] and low everywhere else.
  int busy_lo = 1;
  int busy_hi = 0;

  // Reference model data.
  logic [7:0] rom_exp [3][16] = '{
    '{8'h3F, 8'h28, 8'h2E, 8'h8E, 8'h26, 8'h00, 8'h19, 8'h1E,
      8'h00, 8'h07, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00},
    '{8'h3F, 8'h30, 8'h32, 8'h8E, 8'h26, 8'h00, 8'h22, 8'h23,
      8'h00, 8'h07, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00},
    '{8'h3F, 8'h20, 8'h2A, 8'h8E, 8'h26, 8'h00, 8'h20, 8'h22,
      8'h00, 8'h07, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00}
  };
  logic [7:0] user_exp [16];
  logic [4:0] shadow_exp = 5'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic logic [7:0] bank_val(input logic [1:0] p, input int i);
    if (p == 2'd3) return user_exp[i];
    return rom_exp[p][i];
  endfunction

  function automatic bit in_run(input int c);
    return (c >= busy_lo) && (c <= busy_hi);
  endfunction

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Queue the strobes and the done pulse of a run whose start is driven
  // during cycle s. Events at or after cycle 'cut' are dropped; a reset
  // sampled at the end of cycle cut-1 produces this cut.
  task automatic push_run(input int s, input logic [1:0] p, input logic [15:0] m, input int cut);
    strobe_t e;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        e.at = s + 1 + 2 * i; e.rs = 1'b0; e.di = 8'(i);
        if (e.at < cut) exp_q.push_back(e);
        e.at = s + 2 + 2 * i; e.rs = 1'b1; e.di = bank_val(p, i);
        if (e.at < cut) exp_q.push_back(e);
      end
    end
    e.at = s + 33; e.rs = 1'b0; e.di = {3'b000, shadow_exp};
    if (e.at < cut) exp_q.push_back(e);
    if (s + 34 < cut) done_q.push_back(s + 34);
    busy_lo = s + 1;
    busy_hi = (s + 33 < cut) ? s + 33 : cut - 1;
  endtask

  task automatic start_run(input logic [1:0] p, input logic [15:0] m, input int cut);
    push_run(cyc, p, m, cut);
    start      = 1'b1;
    preset_sel = p;
    mask       = m;
    tick();
    start      = 1'b0;
    preset_sel = 2'd0;
    mask       = 16'h0000;
  endtask

  task automatic cpu_drive_write(input logic rs, input logic [7:0] di);
    strobe_t e;
    cpu_en = 1'b1; cpu_ncs = 1'b0; cpu_rnw = 1'b0; cpu_rs = rs; cpu_di = di;
    if (!in_run(cyc)) begin
      e.at = cyc; e.rs = rs; e.di = di;
      exp_q.push_back(e);
      if (!rs) shadow_exp = di[4:0];
    end
  endtask

  task automatic cpu_release();
    cpu_en = 1'b0; cpu_ncs = 1'b1; cpu_rnw = 1'b1; cpu_rs = 1'b0; cpu_di = 8'h00;
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge CLOCK) begin
    if (mon_en) begin
      strobe_t e;
      int      d;
      check("busy", 32'(busy), 32'(in_run(cyc)));
      check("cpu_wait", 32'(cpu_wait), 32'(in_run(cyc)));
      if (crtc_enable && !crtc_ncs && !crtc_rnw) begin
        if (exp_q.size() == 0) begin
          check("spurious_strobe", {23'd0, crtc_rs, crtc_di}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("strobe_cycle", cyc, e.at);
          check("strobe_rs", 32'(crtc_rs), 32'(e.rs));
          check("strobe_di", 32'(crtc_di), 32'(e.di));
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("spurious_done_cycle", cyc, 32'hFFFF_FFFF);
        end else begin
          d = done_q.pop_front();
          check("done_cycle", cyc, d);
        end
      end
    end
  end

  initial begin
    int s;
    for (int i = 0; i < 16; i++) user_exp[i] = 8'h00;

    // ---- Reset state, IDLE pass-through ----
    repeat (3) tick();
    nRESET = 1'b1;
    mon_en = 1'b1;
    cpu_en = 1'b1; cpu_ncs = 1'b1; cpu_rnw = 1'b1; cpu_rs = 1'b1; cpu_di = 8'hA5;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cpu_wait", 32'(cpu_wait), 32'd0);
    check("idle_fwd_en", 32'(crtc_enable), 32'(cpu_en));
    check("idle_fwd_ncs", 32'(crtc_ncs), 32'(cpu_ncs));
    check("idle_fwd_rnw", 32'(crtc_rnw), 32'(cpu_rnw));
    check("idle_fwd_rs", 32'(crtc_rs), 32'(cpu_rs));
    check("idle_fwd_di", 32'(crtc_di), 32'h0000_00A5);
    tick();
    cpu_release();
    repeat (2) tick();

    // ---- Normal run: standard bank, all registers, restore to 00 ----
    start_run(2'd0, 16'hFFFF, 1 << 30);
    repeat (38) tick();

    // ---- Masked run: overscan bank, only R1/R6/R7 ----
    start_run(2'd1, 16'h00C2, 1 << 30);
    repeat (38) tick();

    // ---- Blocking and restore ----
    cpu_drive_write(1'b0, 8'h03);
    tick();
    cpu_release();
    tick();
    // Address write coincident with start: forwarded, and it wins the shadow.
    cpu_drive_write(1'b0, 8'h0C);
    s = cyc;
    start_run(2'd0, 16'hFFFF, 1 << 30);
    cpu_release();
    repeat (4) tick();                      // now cycle s+5
    for (int k = 0; k < 4; k++) begin       // CPU data writes mid-run
      cpu_drive_write(1'b1, 8'h55);
      tick();
    end
    cpu_release();
    while (cyc < s + 20) tick();
    start = 1'b1; preset_sel = 2'd2; mask = 16'hFFFF;  // ignored: busy
    tick();
    start = 1'b0; preset_sel = 2'd0; mask = 16'h0000;
    repeat (20) tick();

    // ---- Live user bank: write R5 while the run is in progress ----
    s = cyc;
    user_exp[5] = 8'h07;
    start_run(2'd3, 16'hFFFF, 1 << 30);
    repeat (4) tick();                      // cycle s+5
    cfg_we = 1'b1; cfg_idx = 4'd5; cfg_data = 8'h07;
    tick();
    cfg_we = 1'b0; cfg_idx = 4'd0; cfg_data = 8'h00;
    repeat (34) tick();

    // ---- Reset mid-run, then a full run afterwards ----
    s = cyc;
    start_run(2'd0, 16'hFFFF, s + 11);
    repeat (9) tick();                      // cycle s+10
    nRESET = 1'b0;
    tick();
    nRESET = 1'b1;
    shadow_exp = 5'd0;
    for (int i = 0; i < 16; i++) user_exp[i] = 8'h00;
    repeat (3) tick();
    start_run(2'd0, 16'hFFFF, 1 << 30);
    repeat (38) tick();

    check("pending_strobes", exp_q.size(), 32'd0);
    check("pending_done", done_q.size(), 32'd0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
